// File: rtl/gpsreceiver2_pkg.sv
// Shared constants and types for the GPS serial-link transmitter.
package gpsreceiver2_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned SYNC_BIT      = 7;
  localparam int unsigned CNT_W         = 16;
  localparam logic [CNT_W-1:0] UNDERRUN_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : gpsreceiver2_pkg

// File: rtl/gpsreceiver2_tx_fifo.sv
// Single-clock show-ahead byte FIFO with full/empty flags.
module gpsreceiver2_tx_fifo
  import gpsreceiver2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [BITS_PER_BYTE-1:0] din,
  input  logic                     pop,
  output logic [BITS_PER_BYTE-1:0] dout,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2 + 1;

  logic [BITS_PER_BYTE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                 (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  assign dout  = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

  // Pointer update; push and pop are pre-qualified by the caller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= din;
  end

endmodule : gpsreceiver2_tx_fifo

// File: rtl/gpsreceiver2_tx.sv
// Byte-to-serial transmitter: FIFO-buffered bytes sent LSB-first with bit clock and sync.
module gpsreceiver2_tx
  import gpsreceiver2_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        gps_tx_clk,
  output logic        gps_tx_data,
  output logic        gps_tx_sync,
  output logic        busy,
  output logic [15:0] underrun_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BC_W  = $clog2(BITS_PER_BYTE);

  logic [DIV_W-1:0]         div_q;
  logic [DIV_W-1:0]         div_nxt;
  logic                     tick;

  state_t                   state_q, state_d;
  logic [BITS_PER_BYTE-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]          bitcnt_q, bitcnt_d;
  logic                     data_d, sync_d, busy_d, clk_d;
  logic [CNT_W-1:0]         urun_d;

  logic                     fifo_push, fifo_pop;
  logic                     fifo_full, fifo_empty;
  logic [BITS_PER_BYTE-1:0] fifo_dout;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;

  gpsreceiver2_tx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (fifo_push),
    .din   (tx_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_nxt = tick ? '0 : div_q + DIV_W'(1);

  // Free-running bit-period divider.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div_q <= '0;
    else            div_q <= div_nxt;
  end

  // Next-state, shifter and output logic; all changes on a tick except the bit clock.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    data_d   = gps_tx_data;
    sync_d   = gps_tx_sync;
    busy_d   = busy;
    urun_d   = underrun_count;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        data_d = 1'b0;
        sync_d = 1'b0;
        busy_d = 1'b0;
        if (tick && enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          data_d   = fifo_dout[0];
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bitcnt_q == BC_W'(SYNC_BIT)) begin
            sync_d = 1'b0;
            if (enable && !fifo_empty) begin
              // Back-to-back load, no idle bit between bytes.
              fifo_pop = 1'b1;
              shreg_d  = fifo_dout;
              data_d   = fifo_dout[0];
              bitcnt_d = '0;
            end else begin
              if (enable && (underrun_count != UNDERRUN_MAX)) begin
                urun_d = underrun_count + CNT_W'(1);
              end
              data_d  = 1'b0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            shreg_d  = shreg_q >> 1;
            data_d   = shreg_q[1];
            bitcnt_d = bitcnt_q + BC_W'(1);
            sync_d   = ((bitcnt_q + BC_W'(1)) == BC_W'(SYNC_BIT));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit clock is high for the second half of each bit, held low when idle.
    clk_d = (state_d == SHIFT) && (div_nxt >= DIV_W'(CLK_DIV / 2));
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bitcnt_q       <= '0;
      gps_tx_data    <= 1'b0;
      gps_tx_sync    <= 1'b0;
      gps_tx_clk     <= 1'b0;
      busy           <= 1'b0;
      underrun_count <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bitcnt_q       <= bitcnt_d;
      gps_tx_data    <= data_d;
      gps_tx_sync    <= sync_d;
      gps_tx_clk     <= clk_d;
      busy           <= busy_d;
      underrun_count <= urun_d;
    end
  end

endmodule : gpsreceiver2_tx

// File: doc/gpsreceiver2_tx.md
Name: gpsreceiver2_tx

Overview:
Byte-to-serial transmitter for the GPS front-end serial link. It is the transmit-side counterpart of the link deserializer and is used as a loopback/test-pattern source for the receiver path.
- Accepts bytes from the system side through a valid/ready handshake and buffers them in a small FIFO.
- Emits them LSB-first on one data line, with a bit clock and a per-byte sync strobe, in the same format the receiver deserializes.

Parameters:
CLK_DIV, 4, sys_clk cycles per serial bit; must be even and >= 2.
FIFO_DEPTH_LOG2, 3, log2 of byte FIFO depth (default 8 entries).

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = transmit when data available; 0 = finish current byte then idle
tx_byte  input  8  byte to send
tx_valid  input  1  tx_byte valid
tx_ready  output  1  FIFO not full; a byte is accepted when tx_valid & tx_ready
gps_tx_clk  output  1  serial bit clock; rising edge at mid-bit
gps_tx_data  output  1  serial data, LSB first
gps_tx_sync  output  1  high during bit 7 of every byte
busy  output  1  shifter active
underrun_count  output  16  saturating count of underrun events

Behaviour:
Reset (async, sys_rst_n=0):
- FIFO empty; tx_ready=1.
- gps_tx_clk, gps_tx_data, gps_tx_sync and busy = 0; underrun_count = 0.
- Divider counter = 0; FSM = IDLE.
- Reset asserted mid-byte aborts immediately. The partial byte is lost and the FIFO is flushed.

Bit timing:
- Divider counts 0..CLK_DIV-1 and wraps. It free-runs whenever out of reset.
- Tick is asserted when divider == CLK_DIV-1.
- gps_tx_clk is registered: low for divider < CLK_DIV/2, high otherwise. It toggles only in SHIFT and is held 0 in IDLE.
- Data and sync change only on the cycle after a tick, so they are stable at the gps_tx_clk rising edge.

FIFO:
- Push on tx_valid & tx_ready.
- Pop only by the FSM load on a tick.
- Simultaneous push and pop while full: the push is refused, because tx_ready reflects the full state of the current cycle.
- Simultaneous push and pop while empty: the FSM does not see the new byte until the next tick.

FSM:
IDLE
- On tick, if enable & FIFO non-empty: pop the byte into the shift register, drive bit0, bitcnt=0, busy=1, go to SHIFT.
- Otherwise gps_tx_data = 0.

SHIFT
- On each tick, bitcnt++ and drive the next bit.
- gps_tx_sync = 1 exactly while bitcnt == 7 (one bit period).
- On the tick ending bit 7:
  - If enable & FIFO non-empty: load the next byte back-to-back with no gap; remain in SHIFT.
  - Else if enable & FIFO empty: underrun. Increment underrun_count (saturates at 0xFFFF); data/sync = 0; busy = 0; go to IDLE.
  - Else (enable = 0): go to IDLE with no underrun count.
- Deasserting enable mid-byte never truncates the byte.

Throughput: one byte per 8*CLK_DIV cycles in steady state.

Latency: first data bit appears at most CLK_DIV+1 cycles after the push into an empty FIFO while idle.

Decomposition:
- Shared package gpsreceiver2_pkg holds the constants:
  - BITS_PER_BYTE = 8
  - SYNC_BIT = 7
  - state encoding IDLE/SHIFT
  - UNDERRUN_MAX = 16'hFFFF
- One sub-module, gpsreceiver2_tx_fifo: synchronous single-clock FIFO, parameterized by FIFO_DEPTH_LOG2, with full/empty flags. The FSM, divider and shifter stay in the top module.

Test Plan:
1. Reset mid-byte: assert sys_rst_n=0 during bit 3 -> all outputs 0 within 0 cycles (async); after release, no residual bits sent and tx_ready=1.
2. Single byte, CLK_DIV=4: push 0xA5 with enable=1 -> data sequence 1,0,1,0,0,1,0,1 (LSB first), one bit per 4 cycles; sync high only during the 8th bit; then underrun_count=1, busy=0.
3. Back-to-back: push 0x01,0x80,0xFF -> 24 contiguous bits with no gap; sync pulses at bits 7, 15, 23; underrun_count=1 at the end. A deserializer model sampling on gps_tx_clk rising edges recovers 0x01,0x80,0xFF.
4. FIFO full: with enable=0, push 9 bytes -> tx_ready=0 after the 8th; the 9th is not accepted. Then enable=1 -> exactly 8 bytes sent in order.
5. Enable drop mid-byte: deassert enable at bit 2 of 0x3C with 0x55 queued -> 0x3C completes; 0x55 is not started; underrun_count unchanged; on re-enable 0x55 is sent.
6. Underrun saturation: force underrun_count to 0xFFFE, then cause 3 underruns -> counter reads 0xFFFF and holds.
